seg_scroll_ctrl: RTL

//   Parametrised scrolling-message driver for a multiplexed N-digit 7-segment display.

---
 rtl/seg_scroll_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seg_scroll_ctrl.sv
// Scrolling-message driver for a multiplexed N-digit 7-segment display with
// debounced speed/direction/pause buttons and a host-writable pattern buffer.
module seg_scroll_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int MSG_LEN      = 16,
  parameter int REFRESH_DIV  = 1024,
  parameter int BASE_PERIOD  = 2**22,
  parameter int SPEED_LEVELS = 6,
  parameter int DEBOUNCE     = 2**16,
  parameter int W_LED        = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       btn_fast_i,
  input  logic                       btn_slow_i,
  input  logic                       btn_dir_i,
  input  logic                       btn_pause_i,
  input  logic                       msg_wr_i,
  input  logic [$clog2(MSG_LEN)-1:0] msg_addr_i,
  input  logic [7:0]                 msg_data_i,
  output logic [N_DIGITS-1:0]        an_o,
  output logic [7:0]                 seg_o,
  output logic [W_LED-1:0]           led_o
);
  localparam int AW = $clog2(MSG_LEN);
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int LW = (SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1;
  localparam int TW = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  // Button index: 0 fast, 1 slow, 2 dir, 3 pause
  logic [3:0]         btn_raw, s1_q, s2_q, stb_q, rel_q;
  logic [3:0][CW-1:0] dcnt_q;

  assign btn_raw = {btn_pause_i, btn_dir_i, btn_slow_i, btn_fast_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= '0;
      s2_q   <= '0;
      stb_q  <= '0;
      rel_q  <= '0;
      dcnt_q <= '0;
    end else begin
      s1_q  <= btn_raw;
      s2_q  <= s1_q;
      rel_q <= '0;
      for (int b = 0; b < 4; b++) begin
        if (s2_q[b] == stb_q[b]) begin
          dcnt_q[b] <= '0;
        end else if (dcnt_q[b] == CW'(DEBOUNCE - 1)) begin
          // Accepted change; a 1->0 acceptance raises the release pulse
          dcnt_q[b] <= '0;
          stb_q[b]  <= s2_q[b];
          rel_q[b]  <= stb_q[b];
        end else begin
          dcnt_q[b] <= dcnt_q[b] + CW'(1);
        end
      end
    end
  end

  logic [LW-1:0] lvl_q, lvl_d;
  logic          dir_q, dir_d, pause_q, pause_d;
  logic [AW-1:0] ofs_q, ofs_d, idx;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [TW:0]   per;
  logic          step;
  logic [RW-1:0] ref_q, ref_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [AW:0]   sum;
  logic [N_DIGITS-1:0] an_d;
  logic [W_LED-1:0]    led_d;
  logic [7:0]    mem_q [MSG_LEN];
  logic [N_DIGITS-1:0] an_q;
  logic [7:0]    seg_q;
  logic [W_LED-1:0]    led_q;

  always_comb begin
    lvl_d   = lvl_q;
    dir_d   = dir_q ^ rel_q[2];
    pause_d = pause_q ^ rel_q[3];
    if (rel_q[0] && !rel_q[1] && lvl_q != LW'(SPEED_LEVELS - 1))
      lvl_d = lvl_q + LW'(1);
    else if (rel_q[1] && !rel_q[0] && lvl_q != '0)
      lvl_d = lvl_q - LW'(1);

    per   = (TW+1)'(BASE_PERIOD) >> lvl_q;
    step  = (tmr_q == TW'(per - (TW+1)'(1)));
    tmr_d = step ? '0 : tmr_q + TW'(1);
    if (lvl_d != lvl_q) tmr_d = '0;

    // Step uses the pre-toggle direction
    ofs_d = ofs_q;
    if (step && !pause_q) begin
      if (!dir_q) ofs_d = (ofs_q == AW'(MSG_LEN - 1)) ? '0 : ofs_q + AW'(1);
      else        ofs_d = (ofs_q == '0) ? AW'(MSG_LEN - 1) : ofs_q - AW'(1);
    end

    ref_d = ref_q + RW'(1);
    dig_d = dig_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      dig_d = (dig_q == DW'(N_DIGITS - 1)) ? '0 : dig_q + DW'(1);
    end

    sum = {1'b0, ofs_q} + (AW+1)'(dig_q);
    if (sum >= (AW+1)'(MSG_LEN)) sum = sum - (AW+1)'(MSG_LEN);
    idx  = sum[AW-1:0];
    an_d = ~(N_DIGITS'(1) << dig_q);

    led_d = '0;
    led_d[W_LED-1] = pause_q;
    led_d[W_LED-2] = dir_q;
    for (int i = 0; i < SPEED_LEVELS - 1; i++) led_d[i] = (lvl_q > LW'(i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl_q   <= '0;
      dir_q   <= 1'b0;
      pause_q <= 1'b0;
      ofs_q   <= '0;
      tmr_q   <= '0;
      ref_q   <= '0;
      dig_q   <= '0;
      an_q    <= '1;
      seg_q   <= 8'hFF;
      led_q   <= '0;
      for (int i = 0; i < MSG_LEN; i++) mem_q[i] <= 8'hFF;
    end else begin
      lvl_q   <= lvl_d;
      dir_q   <= dir_d;
      pause_q <= pause_d;
      ofs_q   <= ofs_d;
      tmr_q   <= tmr_d;
      ref_q   <= ref_d;
      dig_q   <= dig_d;
      led_q   <= led_d;
      // Anode and segment latch together at the start of each digit slot
      if (ref_q == '0) begin
        an_q  <= an_d;
        seg_q <= mem_q[idx];
      end
      if (msg_wr_i && ({1'b0, msg_addr_i} < (AW+1)'(MSG_LEN)))
        mem_q[msg_addr_i] <= msg_data_i;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign led_o = led_q;
endmodule
